// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, baud divisor and parity helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clock cycles per bit, floored by integer divide and clamped to the supported minimum of 4.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        int quot;
        quot = clk_freq / baud_rate;
        if (quot < 4) begin
            return 4;
        end else begin
            return quot;
        end
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous board inputs; RESET_VAL sets the value held in reset.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receiver: 8N1 deserializer with mid-bit sampling and registered valid/error strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rxd,
    output logic [UART_DATA_BITS-1:0] uart_rx_data,
    output logic                      uart_rx_valid,
    output logic                      uart_rx_busy,
    output logic                      uart_rx_frame_err,
    output logic                      uart_rx_parity_err
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB + 1);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(UART_DATA_BITS - 1);

    logic rxs_s;
    logic rxs_prev_r;
    logic fall_r;

    uart_state_e state_r;
    uart_state_e state_s;

    logic [CNT_W-1:0]          baud_cnt_r;
    logic [CNT_W-1:0]          baud_cnt_s;
    logic [BIT_W-1:0]          bit_cnt_r;
    logic [BIT_W-1:0]          bit_cnt_s;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] shift_s;
    logic                      stop_bit_r;
    logic                      stop_bit_s;
    logic                      done_r;
    logic                      done_s;

    logic [UART_DATA_BITS-1:0] data_r;
    logic [UART_DATA_BITS-1:0] data_s;
    logic                      valid_r;
    logic                      valid_s;
    logic                      busy_r;
    logic                      frame_err_r;
    logic                      frame_err_s;
    logic                      parity_err_s;

`ifdef UART_RX_PARITY_EN
    logic par_bit_r;
    logic par_bit_s;
    logic parity_err_r;
`endif

    uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (uart_rxd),
        .q     (rxs_s)
    );

    // Registered start-edge detector on the synchronized line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxs_prev_r <= 1'b1;
            fall_r     <= 1'b0;
        end else begin
            rxs_prev_r <= rxs_s;
            fall_r     <= rxs_prev_r & ~rxs_s;
        end
    end

    // Next-state, datapath and strobe decode; STOP spends one extra cycle (done_r) issuing the result.
    always_comb begin
        state_s      = state_r;
        baud_cnt_s   = baud_cnt_r + CNT_W'(1);
        bit_cnt_s    = bit_cnt_r;
        shift_s      = shift_r;
        stop_bit_s   = stop_bit_r;
        done_s       = 1'b0;
        data_s       = data_r;
        valid_s      = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_s    = par_bit_r;
`endif
        case (state_r)
            ST_IDLE: begin
                baud_cnt_s = '0;
                bit_cnt_s  = '0;
                if (fall_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_cnt_r == CNT_HALF_LAST) begin
                    baud_cnt_s = '0;
                    // A high line at mid start bit means the edge was noise.
                    if (rxs_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_cnt_r == CNT_BIT_LAST) begin
                    baud_cnt_s = '0;
                    shift_s    = {rxs_s, shift_r[UART_DATA_BITS-1:1]};
                    bit_cnt_s  = bit_cnt_r + BIT_W'(1);
                    if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (baud_cnt_r == CNT_BIT_LAST) begin
                    baud_cnt_s = '0;
                    par_bit_s  = rxs_s;
                    state_s    = ST_STOP;
                end else begin
                    state_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (done_r) begin
                    baud_cnt_s  = '0;
                    state_s     = ST_IDLE;
                    frame_err_s = ~stop_bit_r;
`ifdef UART_RX_PARITY_EN
                    parity_err_s = (par_bit_r != even_parity(shift_r));
`else
                    parity_err_s = 1'b0;
`endif
                    valid_s = stop_bit_r & ~parity_err_s;
                    if (valid_s) begin
                        data_s = shift_r;
                    end else begin
                        data_s = data_r;
                    end
                end else if (baud_cnt_r == CNT_BIT_LAST) begin
                    baud_cnt_s = '0;
                    stop_bit_s = rxs_s;
                    done_s     = 1'b1;
                    state_s    = ST_STOP;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = '0;
                bit_cnt_s  = '0;
            end
        endcase
    end

    // FSM, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            baud_cnt_r  <= '0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            stop_bit_r  <= 1'b1;
            done_r      <= 1'b0;
            data_r      <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_cnt_r  <= baud_cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            stop_bit_r  <= stop_bit_s;
            done_r      <= done_s;
            data_r      <= data_s;
            valid_r     <= valid_s;
            busy_r      <= (state_s != ST_IDLE);
            frame_err_r <= frame_err_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity capture and parity-error strobe register.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            par_bit_r    <= par_bit_s;
            parity_err_r <= parity_err_s;
        end
    end

    assign uart_rx_parity_err = parity_err_r;
`else
    assign uart_rx_parity_err = 1'b0;
`endif

    assign uart_rx_data      = data_r;
    assign uart_rx_valid     = valid_r;
    assign uart_rx_busy      = busy_r;
    assign uart_rx_frame_err = frame_err_r;

endmodule

// File: doc/uart_rx_deser.md
# uart_rx_deser

Serial-to-parallel UART receiver: the receive-side counterpart of the sum-latch system's UART transmitter. It accepts 8N1 frames on `uart_rxd`, samples each bit at mid-bit from a clock-derived baud counter, and presents each byte with a one-cycle valid strobe, so the board can loop back and check the transmitted sums. It sits beside the transmitter under the same top-level wrapper, on the same board clock.

## Interface
- `CLK_FREQ`, default 50_000_000: board clock in Hz.
- `BAUD_RATE`, default 9600: line rate. `CLKS_PER_BIT = CLK_FREQ / BAUD_RATE` (integer divide), minimum 4.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `uart_rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `uart_rx_data` output 8: last successfully received byte.
- `uart_rx_valid` output 1: one-cycle pulse when `uart_rx_data` updates.
- `uart_rx_busy` output 1: high while a frame is being received.
- `uart_rx_frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `uart_rx_parity_err` output 1: one-cycle pulse on a parity mismatch. Tied 0 when parity is compiled out.

## Operation
- The input passes through a 2-FF synchronizer (reset value 1) to give `rxs`. A start is detected on the `rxs` falling edge (previous 1, current 0).
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: bit counter 0, baud counter 0. A falling edge on `rxs` moves to START.
- START: wait `CLKS_PER_BIT/2` cycles (floor), then sample `rxs`.
  - If 0: go to DATA.
  - If 1: the start was a glitch; return to IDLE with no pulses.
- DATA: every `CLKS_PER_BIT` cycles, sample into the shift register, LSB first. After bit 7, go to PARITY (or STOP).
- PARITY: after `CLKS_PER_BIT` cycles, sample; go to STOP.
- STOP: after `CLKS_PER_BIT` cycles, sample.
  - Sample 1 with no parity error: load `uart_rx_data` and pulse `uart_rx_valid`.
  - Sample 0: pulse `uart_rx_frame_err`. `uart_rx_data` is unchanged and no valid pulse is issued.
  - Parity mismatch: pulse `uart_rx_parity_err` only. This applies even when the stop bit is good.
  - In all cases, return to IDLE.
- Error pulses and the valid pulse are mutually exclusive. Frame and parity errors may pulse together.
- Break (line held low): no re-trigger until `rxs` returns high and falls again.
- `uart_rx_busy` is high in START, DATA, PARITY and STOP, and low in IDLE.
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. No pulse is emitted.

## Timing
- Reset values: `uart_rx_data` = 0x00; `uart_rx_valid`, `uart_rx_busy`, `uart_rx_frame_err`, `uart_rx_parity_err` = 0; synchronizer = 1.
- Let t0 be the first `clk` edge that captures `uart_rxd` low.
- The falling edge on `rxs` is seen at t0+2, and START is entered at t0+3.
- The start sample is taken at t0+3+`CLKS_PER_BIT/2`. Each later sample follows the previous one by `CLKS_PER_BIT` cycles.
- `uart_rx_valid`/error pulses are registered and occur one cycle after the stop sample. That is t0+4+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`, or +10·`CLKS_PER_BIT` with parity.
- `uart_rx_busy` rises at t0+3 and falls in the same cycle as the valid or error pulse.
- A new start edge is accepted in the cycle after the return to IDLE. Back-to-back frames with a one-bit stop are received without loss.

## Configuration
- `UART_RX_PARITY_EN`, when defined: each frame carries one even-parity bit between bit 7 and the stop bit (8E1). A mismatch pulses `uart_rx_parity_err` and suppresses `uart_rx_valid`.
- Not defined: 8N1 framing, the PARITY state does not exist, and `uart_rx_parity_err` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum, shared with the transmitter;
  - `UART_DATA_BITS = 8`;
  - a function computing `CLKS_PER_BIT` from `CLK_FREQ`/`BAUD_RATE`, used by both TX and RX.
- One sub-module, `uart_sync2`: the 2-FF synchronizer with a parameterized reset value. It is reused for other asynchronous board inputs.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD_RATE`=100_000 (`CLKS_PER_BIT`=10).
- Send byte 0xA5 as 8N1 → `uart_rx_data`=0xA5, a single `uart_rx_valid` pulse at t0+99, `uart_rx_busy` high for t0+3..t0+99.
- Send 0x00 then 0xFF back-to-back → two valid pulses 100 cycles apart with data 0x00 then 0xFF, and no errors.
- Send 0x3C with the stop bit low → `uart_rx_frame_err` pulses once, `uart_rx_data` keeps its previous value, no valid pulse.
- Pull `uart_rxd` low for 3 cycles, then high → no pulses, `uart_rx_busy` drops back at the start sample (t0+8).
- Assert `reset` at bit 4 of 0x5A, then release and send 0x81 → no pulse for 0x5A, `uart_rx_data`=0x81 afterwards.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 (wrong) → `uart_rx_parity_err` pulses and no valid pulse. The same frame with parity bit 1 → valid, data 0x07.
